paddle_position_ctrl: RTL

PADDLE_POSITION_CTRL -- requirements
Module: paddle_position_ctrl

---
 rtl/game_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 31 +++
 rtl/paddle_position_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the paddle controller.
// Holds the parameter defaults, the encoder code encodings, the controller
// FSM state enum and the move-direction enum used by paddle_position_ctrl.
package game_pkg;

  localparam int unsigned POS_W        = 10;
  localparam int unsigned X_MIN_DEF    = 0;
  localparam int unsigned X_MAX_DEF    = 560;
  localparam int unsigned X_INIT_DEF   = 280;
  localparam int unsigned STEP_DEF     = 4;
  localparam int unsigned STEP_MAX_DEF = 32;
  localparam int unsigned ACC_WIN_DEF  = 25_000_000;

  // Encoder code = {right, left}.
  localparam logic [1:0] CODE_IDLE  = 2'b00;
  localparam logic [1:0] CODE_CCW   = 2'b01;
  localparam logic [1:0] CODE_CW    = 2'b10;
  localparam logic [1:0] CODE_PRESS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_PRESS
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_CCW,
    DIR_CW
  } dir_e;

endpackage

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
// Two flip-flop synchronizer for asynchronous level inputs.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-low reset, clears both stages
//   d    - asynchronous input levels
//   q    - synchronized levels, two clk edges behind d
module sync_2ff #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/paddle_position_ctrl.sv
`timescale 1ns/1ps
// Rotary-encoder paddle position controller.
// Turns encoder detents into clamped paddle moves with same-direction
// acceleration, and the encoder push-switch into a fire pulse.
// Pipeline: sync (2 edges) -> event register -> FSM -> registered outputs,
// so outputs update on the 4th clk edge after the edge that first samples
// new input levels.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   left  - encoder CCW level (asynchronous)
//   right - encoder CW level (asynchronous)
//   en    - game running; events are dropped while low
//   pos   - paddle x position
//   moved - one-cycle pulse when pos changes
//   fire  - one-cycle pulse on switch press
module paddle_position_ctrl
  import game_pkg::*;
#(
  parameter int unsigned X_MIN    = X_MIN_DEF,
  parameter int unsigned X_MAX    = X_MAX_DEF,
  parameter int unsigned X_INIT   = X_INIT_DEF,
  parameter int unsigned STEP     = STEP_DEF,
  parameter int unsigned STEP_MAX = STEP_MAX_DEF,
  parameter int unsigned ACC_WIN  = ACC_WIN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             left,
  input  logic             right,
  input  logic             en,
  output logic [POS_W-1:0] pos,
  output logic             moved,
  output logic             fire
);

  localparam int unsigned GAP_W = $clog2(ACC_WIN + 1);

  localparam logic [POS_W-1:0] X_MIN_P    = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] X_MAX_P    = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] X_INIT_P   = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] STEP_P     = POS_W'(STEP);
  localparam logic [POS_W-1:0] STEP_MAX_P = POS_W'(STEP_MAX);
  localparam logic [POS_W:0]   STEP_MAX_W = (POS_W+1)'(STEP_MAX);
  localparam logic [GAP_W-1:0] ACC_WIN_G  = GAP_W'(ACC_WIN);

  logic [1:0]       code;
  logic [1:0]       code_prev;
  logic [1:0]       evt_code;
  logic             evt_q;

  state_e           state_q, state_d;
  dir_e             cur_dir, last_dir;

  logic [POS_W-1:0] step_reg, step_use, pos_next;
  logic [GAP_W-1:0] gap_cnt;
  logic [POS_W:0]   step_dbl, sum;
  logic signed [POS_W:0] diff;

  sync_2ff #(.WIDTH(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({right, left}),
    .q   (code)
  );

  // Event fires once per change to a non-idle code; a held code stays quiet.
  // The edge register keeps tracking even while events are being dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_prev <= CODE_IDLE;
      evt_code  <= CODE_IDLE;
      evt_q     <= 1'b0;
    end else begin
      code_prev <= code;
      evt_code  <= code;
      evt_q     <= (code != code_prev) && (code != CODE_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (evt_q && en) begin
          case (evt_code)
            CODE_PRESS:        state_d = ST_PRESS;
            CODE_CCW, CODE_CW: state_d = ST_MOVE;
            default:           state_d = ST_IDLE;
          endcase
        end
      end
      ST_MOVE, ST_PRESS: state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  // Step selection and clamped position update. 11-bit arithmetic keeps
  // the CCW underflow negative and the CW overflow above X_MAX.
  always_comb begin
    step_dbl = {step_reg, 1'b0};
    step_use = STEP_P;
    if ((last_dir == cur_dir) && (gap_cnt < ACC_WIN_G)) begin
      step_use = (step_dbl > STEP_MAX_W) ? STEP_MAX_P : step_dbl[POS_W-1:0];
    end
    diff = $signed({1'b0, pos}) - $signed({1'b0, step_use});
    sum  = {1'b0, pos} + {1'b0, step_use};
    if (cur_dir == DIR_CCW) begin
      pos_next = (diff < $signed({1'b0, X_MIN_P})) ? X_MIN_P : diff[POS_W-1:0];
    end else begin
      pos_next = (sum > {1'b0, X_MAX_P}) ? X_MAX_P : sum[POS_W-1:0];
    end
  end

  // Outputs are registered at the end of the MOVE/PRESS cycle, so a reset
  // during that cycle aborts the pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos      <= X_INIT_P;
      moved    <= 1'b0;
      fire     <= 1'b0;
      step_reg <= STEP_P;
      gap_cnt  <= ACC_WIN_G;
      last_dir <= DIR_NONE;
      cur_dir  <= DIR_NONE;
    end else begin
      moved <= 1'b0;
      fire  <= 1'b0;
      if ((state_q == ST_IDLE) && (state_d == ST_MOVE)) begin
        cur_dir <= (evt_code == CODE_CCW) ? DIR_CCW : DIR_CW;
      end
      if (state_q == ST_MOVE) begin
        pos      <= pos_next;
        moved    <= (pos_next != pos);
        step_reg <= step_use;
        last_dir <= cur_dir;
        gap_cnt  <= '0;
      end else if (gap_cnt != ACC_WIN_G) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
      if (state_q == ST_PRESS) fire <= 1'b1;
    end
  end

endmodule
